// File: rtl/uart_tx_frame_counter.sv
// rtl/uart_tx_frame_counter.sv - UART TX frame/bit sequencer (baud prescaler + phase FSM + bit index)
//
// Produces START/DATA/PARITY/STOP timing for the TX shift/mux stage.
// Frames carry 5..MAX_DATA_BITS data bits, optional parity and 1 or 2 stop bits.
// Frame configuration is captured when a frame starts and held until the next frame starts.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RST        in   1      reset, asynchronous, active-low
//   EN         in   1      level enable; high runs frames, low aborts and clears
//   CLK_DIV    in   DIV_W  clock cycles per bit minus 1
//   DATA_BITS  in   4      data bits per frame, clamped to 5..MAX_DATA_BITS
//   PAR_EN     in   1      insert a parity bit
//   STOP2      in   1      two stop bits
//   BAUD_TICK  out  1      high on the last cycle of each bit period
//   PHASE      out  3      0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP
//   BIT_IDX    out  IDX_W  data index in DATA, stop index in STOP, else 0
//   BUSY       out  1      PHASE != IDLE
//   FRAME_DONE out  1      registered one-cycle pulse on normal frame completion

module uart_tx_frame_counter #(
  parameter int DIV_W         = 16,
  parameter int MAX_DATA_BITS = 8,
  parameter int IDX_W         = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [DIV_W-1:0] CLK_DIV,
  input  logic [3:0]       DATA_BITS,
  input  logic             PAR_EN,
  input  logic             STOP2,
  output logic             BAUD_TICK,
  output logic [2:0]       PHASE,
  output logic [IDX_W-1:0] BIT_IDX,
  output logic             BUSY,
  output logic             FRAME_DONE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } phase_t;

  localparam logic [IDX_W-1:0] MAX_LAST = IDX_W'(MAX_DATA_BITS - 1);
  localparam logic [IDX_W-1:0] MIN_LAST = IDX_W'(4);

  phase_t           phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] dlast_q, dlast_d;   // clamped data-bit count minus 1
  logic             par_q, par_d;
  logic             stop2_q, stop2_d;
  logic             done_q, done_d;

  logic [IDX_W-1:0] dlast_in;
  logic [IDX_W-1:0] stop_last;
  logic             tick;
  logic             frame_end;
  logic             load_cfg;

  // Clamp the requested data-bit count and store it as the last data index.
  always_comb begin
    dlast_in = IDX_W'(DATA_BITS) - IDX_W'(1);
    if (DATA_BITS < 4'd5) begin
      dlast_in = MIN_LAST;
    end else if (32'(DATA_BITS) > 32'(MAX_DATA_BITS)) begin
      dlast_in = MAX_LAST;
    end
  end

  assign stop_last = {{(IDX_W-1){1'b0}}, stop2_q};
  assign tick      = (phase_q != S_IDLE) && (presc_q == div_q);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase_q <= S_IDLE;
      idx_q   <= '0;
      presc_q <= '0;
      div_q   <= '0;
      dlast_q <= '0;
      par_q   <= 1'b0;
      stop2_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
      presc_q <= presc_d;
      div_q   <= div_d;
      dlast_q <= dlast_d;
      par_q   <= par_d;
      stop2_q <= stop2_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    idx_d     = idx_q;
    presc_d   = presc_q;
    div_d     = div_q;
    dlast_d   = dlast_q;
    par_d     = par_q;
    stop2_d   = stop2_q;
    done_d    = 1'b0;
    frame_end = 1'b0;
    load_cfg  = 1'b0;

    if (!EN) begin
      // Abort: EN low overrides everything, including a frame completing this cycle.
      phase_d = S_IDLE;
      idx_d   = '0;
      presc_d = '0;
    end else if (phase_q == S_IDLE) begin
      phase_d  = S_START;
      idx_d    = '0;
      presc_d  = '0;
      load_cfg = 1'b1;
    end else if (tick) begin
      presc_d = '0;
      case (phase_q)
        S_START: begin
          phase_d = S_DATA;
          idx_d   = '0;
        end
        S_DATA: begin
          if (idx_q == dlast_q) begin
            phase_d = par_q ? S_PARITY : S_STOP;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        S_PARITY: begin
          phase_d = S_STOP;
          idx_d   = '0;
        end
        S_STOP: begin
          if (idx_q == stop_last) begin
            frame_end = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: begin
          phase_d = S_IDLE;
          idx_d   = '0;
        end
      endcase
    end else begin
      presc_d = presc_q + DIV_W'(1);
    end

    // EN is high here; the next frame starts on the same edge with fresh config.
    if (frame_end) begin
      done_d   = 1'b1;
      phase_d  = S_START;
      idx_d    = '0;
      load_cfg = 1'b1;
    end

    if (load_cfg) begin
      div_d   = CLK_DIV;
      dlast_d = dlast_in;
      par_d   = PAR_EN;
      stop2_d = STOP2;
    end
  end

  assign BAUD_TICK  = tick;
  assign PHASE      = phase_q;
  assign BIT_IDX    = idx_q;
  assign BUSY       = (phase_q != S_IDLE);
  assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_frame_counter.sv
// tb/tb_uart_tx_frame_counter.sv - self-checking bench for uart_tx_frame_counter

module tb_uart_tx_frame_counter;

  localparam int DIV_W = 16;
  localparam int MAXD  = 8;
  localparam int IDX_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             EN = 1'b0;
  logic [DIV_W-1:0] CLK_DIV = '0;
  logic [3:0]       DATA_BITS = 4'd8;
  logic             PAR_EN = 1'b0;
  logic             STOP2 = 1'b0;
  logic             BAUD_TICK;
  logic [2:0]       PHASE;
  logic [IDX_W-1:0] BIT_IDX;
  logic             BUSY;
  logic             FRAME_DONE;

  int tests_run = 0;
  int tests_failed = 0;

  // Expected per-cycle vector: {phase[2:0], idx[3:0], tick, busy}
  logic [8:0] exp_q[$];

  uart_tx_frame_counter #(.DIV_W(DIV_W), .MAX_DATA_BITS(MAXD), .IDX_W(IDX_W)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLK_DIV(CLK_DIV), .DATA_BITS(DATA_BITS),
    .PAR_EN(PAR_EN), .STOP2(STOP2), .BAUD_TICK(BAUD_TICK), .PHASE(PHASE),
    .BIT_IDX(BIT_IDX), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [8:0] obs();
    return {PHASE, BIT_IDX, BAUD_TICK, BUSY};
  endfunction

  // Reference model: a frame is a list of bits, each bit lasting div+1 cycles
  // with the baud tick on its final cycle.
  task automatic push_bit(input int ph, input int idx, input int div);
    for (int c = 0; c <= div; c++)
      exp_q.push_back({3'(ph), 4'(idx), (c == div), 1'b1});
  endtask

  task automatic build_frame(input int div, input int dbits, input bit par, input bit st2);
    int n;
    n = (dbits < 5) ? 5 : ((dbits > MAXD) ? MAXD : dbits);
    exp_q.delete();
    push_bit(1, 0, div);
    for (int d = 0; d < n; d++) push_bit(2, d, div);
    if (par) push_bit(3, 0, div);
    push_bit(4, 0, div);
    if (st2) push_bit(4, 1, div);
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic start_cfg(input int div, input int dbits, input bit par, input bit st2);
    CLK_DIV = DIV_W'(div);
    DATA_BITS = 4'(dbits);
    PAR_EN = par;
    STOP2 = st2;
    EN = 1'b1;
    step();
  endtask

  task automatic test_reset();
    RST = 1'b0;
    EN = 1'b0;
    #12;
    tests_run++;
    if ({obs(), FRAME_DONE} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h expected 000", {obs(), FRAME_DONE});
    end
    @(negedge CLK);
    RST = 1'b1;
    step();
    tests_run++;
    if ({obs(), FRAME_DONE} !== 10'd0) begin
      tests_failed++;
      $display("FAIL reset_idle_en_low: got %h expected 000", {obs(), FRAME_DONE});
    end
  endtask

  task automatic test_8n1();
    build_frame(3, 8, 0, 0);
    start_cfg(3, 8, 0, 0);
    foreach (exp_q[i]) begin
      tests_run++;
      if ({obs(), FRAME_DONE} !== {exp_q[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL 8n1 cyc %0d: got %h expected %h", i, {obs(), FRAME_DONE}, {exp_q[i], 1'b0});
      end
      step();
    end
    tests_run++;
    if ({FRAME_DONE, PHASE} !== {1'b1, 3'd1}) begin
      tests_failed++;
      $display("FAIL 8n1_done_at_40: got %h expected 9", {FRAME_DONE, PHASE});
    end
    EN = 1'b0;
    step();
    tests_run++;
    if ({obs(), FRAME_DONE} !== 10'd0) begin
      tests_failed++;
      $display("FAIL 8n1_idle_after: got %h expected 000", {obs(), FRAME_DONE});
    end
  endtask

  task automatic test_fast_parity();
    build_frame(0, 7, 1, 1);
    start_cfg(0, 7, 1, 1);
    foreach (exp_q[i]) begin
      tests_run++;
      if ({obs(), FRAME_DONE} !== {exp_q[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL 7p2 cyc %0d: got %h expected %h", i, {obs(), FRAME_DONE}, {exp_q[i], 1'b0});
      end
      step();
    end
    tests_run++;
    if ({FRAME_DONE, PHASE} !== {1'b1, 3'd1}) begin
      tests_failed++;
      $display("FAIL 7p2_done_at_11: got %h expected 9", {FRAME_DONE, PHASE});
    end
    EN = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int divs[3] = '{1, 1, 3};
    start_cfg(1, 8, 0, 0);
    for (int f = 0; f < 3; f++) begin
      build_frame(divs[f], 8, 0, 0);
      foreach (exp_q[i]) begin
        tests_run++;
        if ({obs(), FRAME_DONE} !== {exp_q[i], (f > 0 && i == 0)}) begin
          tests_failed++;
          $display("FAIL b2b frame %0d cyc %0d: got %h expected %h", f, i,
                   {obs(), FRAME_DONE}, {exp_q[i], (f > 0 && i == 0)});
        end
        if (f == 1 && i == 5) CLK_DIV = DIV_W'(3);
        step();
      end
    end
    tests_run++;
    if ({FRAME_DONE, PHASE} !== {1'b1, 3'd1}) begin
      tests_failed++;
      $display("FAIL b2b_last_done: got %h expected 9", {FRAME_DONE, PHASE});
    end
    EN = 1'b0;
    step();
    tests_run++;
    if ({obs(), FRAME_DONE} !== 10'd0) begin
      tests_failed++;
      $display("FAIL b2b_idle_after: got %h expected 000", {obs(), FRAME_DONE});
    end
  endtask

  task automatic test_abort();
    build_frame(2, 8, 0, 0);
    start_cfg(2, 8, 0, 0);
    for (int i = 0; i < 13; i++) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL abort_pre cyc %0d: got %h expected %h", i, obs(), exp_q[i]);
      end
      step();
    end
    tests_run++;
    if ({PHASE, BIT_IDX} !== {3'd2, 4'd3}) begin
      tests_failed++;
      $display("FAIL abort_at_d3: got %h expected 23", {PHASE, BIT_IDX});
    end
    EN = 1'b0;
    step();
    tests_run++;
    if ({obs(), FRAME_DONE} !== 10'd0) begin
      tests_failed++;
      $display("FAIL abort_idle: got %h expected 000", {obs(), FRAME_DONE});
    end
    // EN dropped on the final tick of a frame: abort beats completion.
    build_frame(0, 5, 0, 0);
    start_cfg(0, 5, 0, 0);
    foreach (exp_q[i]) begin
      tests_run++;
      if (obs() !== exp_q[i]) begin
        tests_failed++;
        $display("FAIL abort_end cyc %0d: got %h expected %h", i, obs(), exp_q[i]);
      end
      if (i == exp_q.size() - 1) EN = 1'b0;
      step();
    end
    tests_run++;
    if ({obs(), FRAME_DONE} !== 10'd0) begin
      tests_failed++;
      $display("FAIL abort_end_no_done: got %h expected 000", {obs(), FRAME_DONE});
    end
  endtask

  task automatic test_clamp();
    int reqs[2] = '{3, 12};
    for (int k = 0; k < 2; k++) begin
      build_frame(1, reqs[k], 0, 0);
      start_cfg(1, reqs[k], 0, 0);
      foreach (exp_q[i]) begin
        tests_run++;
        if ({obs(), FRAME_DONE} !== {exp_q[i], 1'b0}) begin
          tests_failed++;
          $display("FAIL clamp bits=%0d cyc %0d: got %h expected %h", reqs[k], i,
                   {obs(), FRAME_DONE}, {exp_q[i], 1'b0});
        end
        step();
      end
      tests_run++;
      if (FRAME_DONE !== 1'b1) begin
        tests_failed++;
        $display("FAIL clamp_done bits=%0d: got %b expected 1", reqs[k], FRAME_DONE);
      end
      EN = 1'b0;
      step();
    end
  endtask

  task automatic test_reset_mid();
    build_frame(2, 7, 1, 0);
    start_cfg(2, 7, 1, 0);
    for (int i = 0; i < 25; i++) step();
    tests_run++;
    if (obs() !== exp_q[25]) begin
      tests_failed++;
      $display("FAIL rst_mid_parity: got %h expected %h", obs(), exp_q[25]);
    end
    #2;
    RST = 1'b0;
    #1;
    tests_run++;
    if ({obs(), FRAME_DONE} !== 10'd0) begin
      tests_failed++;
      $display("FAIL rst_async: got %h expected 000", {obs(), FRAME_DONE});
    end
    @(negedge CLK);
    RST = 1'b1;
    step();
    tests_run++;
    if ({obs(), FRAME_DONE} !== {3'd1, 4'd0, 1'b0, 1'b1, 1'b0}) begin
      tests_failed++;
      $display("FAIL rst_restart: got %h expected 082", {obs(), FRAME_DONE});
    end
    EN = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int div, db;
      bit par, st2;
      div = int'($urandom_range(0, 4));
      db  = int'($urandom_range(0, 15));
      par = 1'($urandom_range(0, 1));
      st2 = 1'($urandom_range(0, 1));
      build_frame(div, db, par, st2);
      start_cfg(div, db, par, st2);
      foreach (exp_q[i]) begin
        tests_run++;
        if ({obs(), FRAME_DONE} !== {exp_q[i], 1'b0}) begin
          tests_failed++;
          $display("FAIL rand %0d (div=%0d bits=%0d par=%0d st2=%0d) cyc %0d: got %h expected %h",
                   r, div, db, par, st2, i, {obs(), FRAME_DONE}, {exp_q[i], 1'b0});
        end
        if (i == 1) begin
          CLK_DIV   = DIV_W'($urandom_range(0, 7));
          DATA_BITS = 4'($urandom_range(0, 15));
          PAR_EN    = 1'($urandom_range(0, 1));
          STOP2     = 1'($urandom_range(0, 1));
        end
        step();
      end
      tests_run++;
      if ({FRAME_DONE, PHASE} !== {1'b1, 3'd1}) begin
        tests_failed++;
        $display("FAIL rand_done %0d: got %h expected 9", r, {FRAME_DONE, PHASE});
      end
      EN = 1'b0;
      step();
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_fast_parity();
    test_back_to_back();
    test_abort();
    test_clamp();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
